lab4_fetch_ctrl: RTL and testbench

LAB4_FETCH_CTRL -- requirements
Module: lab4_fetch_ctrl

---
 rtl/lab4_fetch_pkg.sv | 15 +
 rtl/lab4_pc_next.sv | 29 ++
 rtl/lab4_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_lab4_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab4_fetch_pkg.sv
// Shared types and constants for the lab4 instruction fetch controller.
package lab4_fetch_pkg;

  localparam int PC_W   = 8;
  localparam int INSN_W = 16;

  localparam logic [INSN_W-1:0] DEFAULT_HALT_WORD = 16'h0001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/lab4_pc_next.sv
// Next-PC arithmetic: sequential +2 and taken-branch target, each with an
// out-of-range flag used by the optional PC bound check.
module lab4_pc_next
  import lab4_fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] ir_pc,
  input  logic [PC_W-1:0] br_off,
  output logic [PC_W-1:0] seq_pc,
  output logic            seq_ovf,
  output logic [PC_W-1:0] br_pc,
  output logic            br_ovf
);

  logic        [PC_W:0]   seq_sum;
  logic signed [PC_W+1:0] br_sum;

  always_comb begin
    seq_sum = {1'b0, pc} + 9'd2;
    // Word offset is sign-extended and doubled into a byte offset; the extra
    // headroom bits expose both underflow (negative) and overflow (>255).
    br_sum  = $signed({2'b00, ir_pc}) + 10'sd2 + $signed({br_off[PC_W-1], br_off, 1'b0});
    seq_pc  = seq_sum[PC_W-1:0];
    seq_ovf = seq_sum[PC_W];
    br_pc   = br_sum[PC_W-1:0];
    br_ovf  = br_sum[PC_W+1] | br_sum[PC_W];
  end

endmodule

// File: rtl/lab4_fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/HALT sequencer with stall, taken
// branch redirect and halt detection. Define PC_BOUND_CHK_EN to fault on PC overflow.
module lab4_fetch_ctrl
  import lab4_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC  = 8'h00,
  parameter logic [INSN_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STALL,
  input  logic              BR_TAKE,
  input  logic [PC_W-1:0]   BR_OFF,
  input  logic [INSN_W-1:0] IMEM_Q,
  output logic [PC_W-1:0]   IMEM_ADDR,
  output logic [INSN_W-1:0] IR,
  output logic              IR_VALID,
  output logic [PC_W-1:0]   IR_PC,
  output logic              HALTED,
  output logic              FAULT
);

`ifdef PC_BOUND_CHK_EN
  localparam logic BOUND_CHK = 1'b1;
`else
  localparam logic BOUND_CHK = 1'b0;
`endif

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fault_q, fault_d;

  logic [PC_W-1:0]   seq_pc, br_pc;
  logic              seq_ovf, br_ovf;
  logic              bound_hit;

  lab4_pc_next u_pc_next (
    .pc      (pc_q),
    .ir_pc   (ir_pc_q),
    .br_off  (BR_OFF),
    .seq_pc  (seq_pc),
    .seq_ovf (seq_ovf),
    .br_pc   (br_pc),
    .br_ovf  (br_ovf)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;
    bound_hit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
        end
      end
      FETCH: begin
        if (!STALL) begin
          if (BR_TAKE && ir_valid_q) begin
            // Redirect wins over a halt word arriving in the same cycle.
            bound_hit  = BOUND_CHK & br_ovf;
            pc_d       = br_pc;
            ir_valid_d = 1'b0;
          end else begin
            bound_hit  = BOUND_CHK & seq_ovf;
            ir_d       = IMEM_Q;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = seq_pc;
            if (IMEM_Q == HALT_WORD) state_d = HALT;
          end
          if (bound_hit) begin
            state_d    = HALT;
            fault_d    = 1'b1;
            ir_valid_d = 1'b0;
            pc_d       = pc_q;
          end
        end
      end
      HALT: begin
        ir_valid_d = 1'b0;
        if (START) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including IR, is reset and updated with non-blocking
  // assignments so every _q samples the pre-edge _d set together.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign IR        = ir_q;
  assign IR_PC     = ir_pc_q;
  assign IR_VALID  = ir_valid_q;
  assign HALTED    = (state_q == HALT);
  assign FAULT     = fault_q;

endmodule

// File: tb/tb_lab4_fetch_ctrl.sv
// Self-checking bench for lab4_fetch_ctrl: directed scenarios plus a randomized
// run against a behavioural fetch model.
module tb_lab4_fetch_ctrl;

  logic        clk, rst_n, start, stall, br_take;
  logic [7:0]  br_off;
  logic [15:0] imem_q;
  logic [7:0]  imem_addr, ir_pc;
  logic [15:0] ir;
  logic        ir_valid, halted, fault;

  logic [15:0] imem [0:127];
  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;
  int          m_mode, m_pc, m_ir_pc;
  logic [15:0] m_ir;
  logic        m_valid, m_fault;

  assign imem_q = imem[imem_addr[7:1]];

  lab4_fetch_ctrl #(.RESET_PC(8'h00), .HALT_WORD(16'h0001)) dut (
    .CLK(clk), .RESET(rst_n), .START(start), .STALL(stall), .BR_TAKE(br_take),
    .BR_OFF(br_off), .IMEM_Q(imem_q), .IMEM_ADDR(imem_addr), .IR(ir),
    .IR_VALID(ir_valid), .IR_PC(ir_pc), .HALTED(halted), .FAULT(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stall = 1'b0; br_take = 1'b0; br_off = 8'h00;
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 128; i++) imem[i] = 16'h2000 + 16'(i);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_mode = M_IDLE; m_pc = 0; m_ir = 16'h0000; m_ir_pc = 0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  // Behavioural model: one call per clock edge, using the inputs about to be sampled.
  task automatic model_step();
    logic [15:0] word;
    int off, tgt;
    logic bad;
    word = imem[m_pc / 2];
    bad  = 1'b0;
    case (m_mode)
      M_IDLE: if (start) begin m_mode = M_FETCH; m_pc = 0; end
      M_FETCH: if (!stall) begin
        if (br_take && m_valid) begin
          off = br_off[7] ? int'(br_off) - 256 : int'(br_off);
          tgt = m_ir_pc + 2 + 2 * off;
`ifdef PC_BOUND_CHK_EN
          bad = (tgt < 0) || (tgt > 255);
`endif
          if (bad) begin m_mode = M_HALT; m_fault = 1'b1; m_valid = 1'b0; end
          else begin m_pc = (tgt + 512) % 256; m_valid = 1'b0; end
        end else begin
`ifdef PC_BOUND_CHK_EN
          bad = (m_pc == 254);
`endif
          if (bad) begin m_mode = M_HALT; m_fault = 1'b1; m_valid = 1'b0; end
          else begin
            m_ir = word; m_ir_pc = m_pc; m_valid = 1'b1; m_pc = (m_pc + 2) % 256;
            if (word == 16'h0001) m_mode = M_HALT;
          end
        end
      end
      default: begin
        m_valid = 1'b0;
        if (start) begin m_mode = M_FETCH; m_pc = 0; m_fault = 1'b0; end
      end
    endcase
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", imem_addr); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL rst_ir got %h exp 0000", ir); end
    checks++; if (ir_pc !== 8'h00) begin errors++; $display("FAIL rst_ir_pc got %h exp 00", ir_pc); end
    checks++; if ({ir_valid, halted, fault} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {ir_valid, halted, fault}); end
    tick();
    rst_n = 1'b1;
    stall = 1'b1; br_take = 1'b1; br_off = 8'h05;
    repeat (3) tick();
    checks++; if ({imem_addr, ir_valid, halted} !== {8'h00, 2'b00}) begin errors++; $display("FAIL idle_hold got %h/%b/%b exp 00/0/0", imem_addr, ir_valid, halted); end
    idle_inputs();
  endtask

  task automatic test_sequential();
    fill_plain();
    imem[0] = 16'hF001; imem[1] = 16'h1234; imem[2] = 16'h5678;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({imem_addr, ir_valid} !== {8'h00, 1'b0}) begin errors++; $display("FAIL seq_c1 got %h/%b exp 00/0", imem_addr, ir_valid); end
    tick();
    checks++; if ({imem_addr, ir_pc, ir, ir_valid} !== {8'h02, 8'h00, 16'hF001, 1'b1}) begin errors++; $display("FAIL seq_c2 got %h/%h/%h/%b exp 02/00/f001/1", imem_addr, ir_pc, ir, ir_valid); end
    tick();
    checks++; if ({imem_addr, ir_pc, ir, ir_valid} !== {8'h04, 8'h02, 16'h1234, 1'b1}) begin errors++; $display("FAIL seq_c3 got %h/%h/%h/%b exp 04/02/1234/1", imem_addr, ir_pc, ir, ir_valid); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({imem_addr, ir_pc, ir_valid} !== {8'h06, 8'h04, 1'b1}) begin errors++; $display("FAIL seq_start_in_fetch got %h/%h/%b exp 06/04/1", imem_addr, ir_pc, ir_valid); end
  endtask

  task automatic test_branch();
    fill_plain();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if ({ir_pc, ir_valid, imem_addr} !== {8'h08, 1'b1, 8'h0A}) begin errors++; $display("FAIL br_setup got %h/%b/%h exp 08/1/0a", ir_pc, ir_valid, imem_addr); end
    br_take = 1'b1; br_off = 8'h01;
    tick();
    br_take = 1'b0;
    checks++; if ({imem_addr, ir_valid} !== {8'h0C, 1'b0}) begin errors++; $display("FAIL br_fwd got %h/%b exp 0c/0", imem_addr, ir_valid); end
    tick();
    checks++; if ({ir_pc, ir, ir_valid} !== {8'h0C, 16'h2006, 1'b1}) begin errors++; $display("FAIL br_fwd_next got %h/%h/%b exp 0c/2006/1", ir_pc, ir, ir_valid); end
    repeat (2) tick();
    br_take = 1'b1; br_off = 8'hFC; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({imem_addr, ir_pc, ir_valid} !== {8'h12, 8'h10, 1'b1}) begin errors++; $display("FAIL br_stall%0d got %h/%h/%b exp 12/10/1", i, imem_addr, ir_pc, ir_valid); end
    end
    stall = 1'b0;
    tick();
    br_take = 1'b0;
    checks++; if ({imem_addr, ir_valid} !== {8'h0A, 1'b0}) begin errors++; $display("FAIL br_back got %h/%b exp 0a/0", imem_addr, ir_valid); end
  endtask

  task automatic test_halt();
    fill_plain();
    imem[0] = 16'hF001; imem[1] = 16'h0001;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++; if ({ir, ir_pc, ir_valid, halted, imem_addr} !== {16'h0001, 8'h02, 2'b11, 8'h04}) begin errors++; $display("FAIL halt_cap got %h/%h/%b/%b/%h exp 0001/02/1/1/04", ir, ir_pc, ir_valid, halted, imem_addr); end
    repeat (2) tick();
    checks++; if ({ir_valid, halted, imem_addr} !== {2'b01, 8'h04}) begin errors++; $display("FAIL halt_hold got %b/%b/%h exp 0/1/04", ir_valid, halted, imem_addr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({imem_addr, halted, ir_valid} !== {8'h00, 2'b00}) begin errors++; $display("FAIL halt_restart got %h/%b/%b exp 00/0/0", imem_addr, halted, ir_valid); end
    // Taken branch beats a halt word fetched in the same cycle.
    imem[1] = 16'h2001; imem[2] = 16'h0001;
    repeat (2) tick();
    br_take = 1'b1; br_off = 8'h05;
    tick();
    br_take = 1'b0;
    checks++; if ({halted, ir_valid, imem_addr} !== {2'b00, 8'h0E}) begin errors++; $display("FAIL halt_vs_br got %b/%b/%h exp 0/0/0e", halted, ir_valid, imem_addr); end
  endtask

  task automatic test_async_reset();
    fill_plain();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (3) tick();
    checks++; if ({imem_addr, ir_valid} !== {8'h06, 1'b1}) begin errors++; $display("FAIL ares_pre got %h/%b exp 06/1", imem_addr, ir_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({imem_addr, ir, ir_pc, ir_valid, halted, fault} !== {8'h00, 16'h0000, 8'h00, 3'b000}) begin errors++; $display("FAIL ares_now got %h/%h/%h/%b exp 00/0000/00/0", imem_addr, ir, ir_pc, ir_valid); end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if ({imem_addr, ir, ir_valid, halted} !== {8'h00, 16'h0000, 2'b00}) begin errors++; $display("FAIL ares_post got %h/%h/%b/%b exp 00/0000/0/0", imem_addr, ir, ir_valid, halted); end
  endtask

  task automatic test_wrap();
    fill_plain();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (127) tick();
    checks++; if (imem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_pre got %h exp fe", imem_addr); end
    tick();
`ifdef PC_BOUND_CHK_EN
    checks++; if ({fault, halted, ir_valid, imem_addr} !== {3'b110, 8'hFE}) begin errors++; $display("FAIL wrap_fault got %b/%b/%b/%h exp 1/1/0/fe", fault, halted, ir_valid, imem_addr); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({fault, halted, imem_addr} !== {2'b00, 8'h00}) begin errors++; $display("FAIL wrap_clear got %b/%b/%h exp 0/0/00", fault, halted, imem_addr); end
`else
    checks++; if ({imem_addr, ir_pc, ir_valid, fault} !== {8'h00, 8'hFE, 2'b10}) begin errors++; $display("FAIL wrap got %h/%h/%b/%b exp 00/fe/1/0", imem_addr, ir_pc, ir_valid, fault); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 128; i++) begin
      imem[i] = 16'($urandom);
      if (imem[i] == 16'h0001) imem[i] = 16'h8000;
      if ($urandom_range(0, 15) == 0) imem[i] = 16'h0001;
    end
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      start   = ($urandom_range(0, 9) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      br_take = ($urandom_range(0, 2) == 0);
      br_off  = 8'($urandom);
      model_step();
      tick();
      checks++; if (imem_addr !== 8'(m_pc)) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, imem_addr, 8'(m_pc)); end
      checks++; if (ir_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, ir_valid, m_valid); end
      checks++; if (halted !== (m_mode == M_HALT)) begin errors++; $display("FAIL rnd_halted cyc %0d got %b exp %b", cyc, halted, m_mode == M_HALT); end
      checks++; if (fault !== m_fault) begin errors++; $display("FAIL rnd_fault cyc %0d got %b exp %b", cyc, fault, m_fault); end
      if (m_valid) begin
        checks++; if ({ir, ir_pc} !== {m_ir, 8'(m_ir_pc)}) begin errors++; $display("FAIL rnd_ir cyc %0d got %h/%h exp %h/%h", cyc, ir, ir_pc, m_ir, 8'(m_ir_pc)); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    fill_plain();
    test_reset();
    test_sequential();
    test_branch();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
